// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: loader state encoding and bytes-per-word helper
package inst_loader_pkg;
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE} state_t;
  function automatic int bpw(input int dw);
    return (dw + 7) / 8;
  endfunction
endpackage

// File: rtl/inst_loader_word_assembler.sv
// word_assembler: little-endian byte-to-word assembly with a byte slot counter
module word_assembler #(
  parameter int DW  = 9,
  parameter int BPW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [7:0]    byte_in,
  output logic          word_done,
  output logic [DW-1:0] word
);
  localparam int XW = BPW > 1 ? $clog2(BPW) : 1;
  logic [XW-1:0] idx;
  logic [DW-1:0] acc;
  // word shows the accepted byte merged in the same cycle, so the final slot is usable on completion
  for (genvar j = 0; j < DW; j++) begin : g_slot
    assign word[j] = (en && idx == XW'(j / 8)) ? byte_in[j % 8] : acc[j];
  end
  assign word_done = en && idx == XW'(BPW - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      acc <= '0;
    end else begin
      if (clr) idx <= '0;
      else if (en) idx <= word_done ? '0 : idx + XW'(1);
      if (en) acc <= word;
    end
  end
endmodule

// File: rtl/inst_loader.sv
// inst_loader: byte stream to instruction RAM writer; INST_LOADER_CHECKSUM_EN adds an XOR checksum stage
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int IW = 10,
  parameter int DW = 9
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [IW:0]   LoadLen,
  input  logic [7:0]    ByteIn,
  input  logic          ByteValid,
  output logic          ByteReady,
  output logic          WrEn,
  output logic [IW-1:0] WrAddr,
  output logic [DW-1:0] WrData,
  output logic          Busy,
  output logic          Done,
  output logic          ChkErr
);
  localparam int BPW = bpw(DW);
  localparam logic [IW:0] MAX_LEN = {1'b1, {IW{1'b0}}};
`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_t FIN = CHK;
`else
  localparam state_t FIN = DONE;
`endif
  state_t state, state_n;
  logic [IW:0] words_left, len;
  logic start_acc, accept, word_done;
  logic [DW-1:0] word;
  assign len       = LoadLen > MAX_LEN ? MAX_LEN : LoadLen;
  assign start_acc = Start && (state == IDLE || state == DONE);
  assign ByteReady = state == RECV || state == CHK;
  assign accept    = ByteValid && ByteReady;
  assign WrEn      = state == WRITE;
  assign WrData    = word;
  assign Busy      = state == RECV || state == WRITE || state == CHK;
  assign Done      = state == DONE;
  word_assembler #(.DW(DW), .BPW(BPW)) u_asm (
    .clk      (Clk),
    .rst      (Reset),
    .clr      (start_acc),
    .en       (accept),
    .byte_in  (ByteIn),
    .word_done(word_done),
    .word     (word)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start_acc) state_n = len == '0 ? FIN : RECV;
      RECV:       if (word_done) state_n = WRITE;
      WRITE:      state_n = words_left == (IW+1)'(1) ? FIN : RECV;
      CHK:        if (word_done) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      words_left <= '0;
      WrAddr     <= '0;
    end else begin
      state <= state_n;
      if (start_acc) begin
        words_left <= len;
        WrAddr     <= '0;
      end else if (WrEn) begin
        words_left <= words_left - (IW+1)'(1);
        WrAddr     <= WrAddr + IW'(1);
      end
    end
  end
`ifdef INST_LOADER_CHECKSUM_EN
  logic [DW-1:0] xor_q;
  logic chk_err_q;
  always_ff @(posedge Clk) begin
    if (Reset || start_acc) begin
      xor_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (WrEn) xor_q <= xor_q ^ WrData;
      if (state == CHK && word_done) chk_err_q <= word != xor_q;
    end
  end
  assign ChkErr = chk_err_q;
`else
  assign ChkErr = 1'b0;
`endif
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: randomized self-checking bench for inst_loader against a byte-to-word reference model
module tb_inst_loader;
  localparam int IW = 10;
  localparam int DW = 9;
  typedef logic [7:0] bq_t[$];
  typedef logic [DW-1:0] wq_t[$];
  logic Clk = 1'b0;
  logic Reset, Start, ByteValid, ByteReady, WrEn, Busy, Done, ChkErr;
  logic [IW:0] LoadLen;
  logic [7:0] ByteIn;
  logic [IW-1:0] WrAddr;
  logic [DW-1:0] WrData;
  int checks = 0, failures = 0, lat_err = 0, rdy_err = 0;
  bit prev_acc = 1'b0;
  logic [IW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];

  always #5 Clk = ~Clk;

  inst_loader #(.IW(IW), .DW(DW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .LoadLen(LoadLen), .ByteIn(ByteIn),
    .ByteValid(ByteValid), .ByteReady(ByteReady), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrData(WrData), .Busy(Busy), .Done(Done), .ChkErr(ChkErr)
  );

  // Write monitor: every write must follow a byte transfer on the previous edge, with the stream stalled
  always @(negedge Clk) begin
    if (WrEn === 1'b1) begin
      wa_q.push_back(WrAddr);
      wd_q.push_back(WrData);
      if (!prev_acc) lat_err++;
      if (ByteReady !== 1'b0) rdy_err++;
    end
    prev_acc = (ByteValid === 1'b1) && (ByteReady === 1'b1);
  end

  function automatic wq_t model_words(bq_t b, int n);
    wq_t w;
    for (int k = 0; k < n; k++) w.push_back(DW'((int'(b[2*k]) + 256 * int'(b[2*k+1])) % 512));
    return w;
  endfunction

  function automatic logic [DW-1:0] model_xor(wq_t w);
    logic [DW-1:0] x = '0;
    foreach (w[k]) x ^= w[k];
    return x;
  endfunction

  function automatic bq_t rand_bytes(int n);
    bq_t b;
    for (int k = 0; k < n; k++) b.push_back(8'($urandom));
    return b;
  endfunction

  function automatic bq_t with_chk(bq_t b, logic [DW-1:0] x);
    bq_t r = b;
`ifdef INST_LOADER_CHECKSUM_EN
    r.push_back(x[7:0]);
    r.push_back({7'b0, x[8]});
`endif
    return r;
  endfunction

  function automatic int write_mismatches(wq_t exp);
    int bad = (wd_q.size() == exp.size()) ? 0 : 1;
    for (int k = 0; k < wd_q.size() && k < exp.size(); k++)
      if (wa_q[k] !== IW'(k) || wd_q[k] !== exp[k]) bad++;
    return bad;
  endfunction

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    lat_err = 0;
    rdy_err = 0;
  endtask

  task automatic start_load(input logic [IW:0] n);
    Start = 1'b1;
    LoadLen = n;
    @(posedge Clk); #1;
    Start = 1'b0;
    LoadLen = IW'($urandom);
  endtask

  task automatic stream(input bq_t b, input bit rnd);
    int i = 0, t = 0;
    while (i < b.size() && t < 20000) begin
      ByteIn = b[i];
      ByteValid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge Clk);
      if (ByteValid && ByteReady) i++;
      @(posedge Clk); #1;
      t++;
    end
    ByteValid = 1'b0;
    ByteIn = 8'($urandom);
    checks++;
    if (i != b.size()) begin
      failures++;
      $display("FAIL stream_timeout sent=%0d want=%0d", i, b.size());
    end
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    @(negedge Clk);
    while (Done !== 1'b1 && t < 5000) begin
      @(negedge Clk);
      t++;
    end
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_done done=%b busy=%b want done=1 busy=0", name, Done, Busy);
    end
    @(posedge Clk); #1;
  endtask

  task automatic check_stream_rules(input string name);
    checks++;
    if (lat_err !== 0 || rdy_err !== 0) begin
      failures++;
      $display("FAIL %s_timing latency_errs=%0d ready_in_write=%0d want 0/0", name, lat_err, rdy_err);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if ({ByteReady, WrEn, Busy, Done, ChkErr} !== 5'b0 || WrAddr !== '0 || WrData !== '0) begin
      failures++;
      $display("FAIL reset_outputs rdy/wen/busy/done/chk=%b addr=%h data=%h want all 0",
               {ByteReady, WrEn, Busy, Done, ChkErr}, WrAddr, WrData);
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    bq_t b = '{8'h01, 8'h00, 8'hFF, 8'h01, 8'h2A, 8'h00};
    wq_t exp = '{9'h001, 9'h1FF, 9'h02A};
    int bad;
    clear_mon();
    start_load(3);
    stream(with_chk(b, 9'h1D4), 1'b0);
    wait_done("basic");
    bad = write_mismatches(exp);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL basic_writes mismatches=%0d got %0d writes want 3", bad, wd_q.size());
    end
    check_stream_rules("basic");
    checks++;
    if (ChkErr !== 1'b0) begin
      failures++;
      $display("FAIL basic_chkerr got=%b want=0", ChkErr);
    end
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if (Done !== 1'b1) begin
      failures++;
      $display("FAIL done_sticky got=%b want=1", Done);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_random_valid();
    bq_t b = '{8'h01, 8'h00, 8'hFF, 8'h01, 8'h2A, 8'h00};
    wq_t exp;
    int n, bad;
    for (int r = 0; r < 4; r++) begin
      n = (r == 0) ? 3 : $urandom_range(1, 20);
      if (r != 0) b = rand_bytes(2 * n);
      exp = model_words(b, n);
      clear_mon();
      start_load(IW'(n));
      @(negedge Clk);
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b1) begin
        failures++;
        $display("FAIL rand%0d_start done=%b busy=%b want done=0 busy=1", r, Done, Busy);
      end
      @(posedge Clk); #1;
      stream(with_chk(b, model_xor(exp)), 1'b1);
      wait_done("rand");
      bad = write_mismatches(exp);
      checks++;
      if (bad !== 0) begin
        failures++;
        $display("FAIL rand%0d_writes mismatches=%0d got %0d writes want %0d", r, bad, wd_q.size(), n);
      end
      check_stream_rules("rand");
    end
  endtask

  task automatic test_zero_len();
    clear_mon();
    start_load(0);
`ifdef INST_LOADER_CHECKSUM_EN
    stream('{8'h00, 8'h00}, 1'b0);
    wait_done("zero");
    checks++;
    if (ChkErr !== 1'b0) begin
      failures++;
      $display("FAIL zero_chkerr got=%b want=0", ChkErr);
    end
`else
    @(negedge Clk);
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_done done=%b busy=%b want done=1 busy=0", Done, Busy);
    end
    @(posedge Clk); #1;
`endif
    checks++;
    if (wd_q.size() !== 0) begin
      failures++;
      $display("FAIL zero_writes got=%0d want=0", wd_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bq_t b = rand_bytes(6);
    wq_t exp;
    int bad;
    clear_mon();
    start_load(3);
    stream('{b[0], b[1], b[2], b[3], b[4]}, 1'b1);
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    checks++;
    if ({ByteReady, WrEn, Busy, Done, ChkErr} !== 5'b0 || WrAddr !== '0 || WrData !== '0) begin
      failures++;
      $display("FAIL midreset_outputs rdy/wen/busy/done/chk=%b addr=%h data=%h want all 0",
               {ByteReady, WrEn, Busy, Done, ChkErr}, WrAddr, WrData);
    end
    checks++;
    if (wd_q.size() !== 2) begin
      failures++;
      $display("FAIL midreset_partial got=%0d writes want=2", wd_q.size());
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    b = rand_bytes(4);
    exp = model_words(b, 2);
    clear_mon();
    start_load(2);
    stream(with_chk(b, model_xor(exp)), 1'b1);
    wait_done("reload");
    bad = write_mismatches(exp);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reload_writes mismatches=%0d got %0d writes want 2", bad, wd_q.size());
    end
  endtask

  task automatic test_busy_clamp();
    bq_t b = rand_bytes(2048);
    bq_t head, tail;
    wq_t exp = model_words(b, 1024);
    int bad;
    for (int k = 0; k < 2048; k++)
      if (k < 10) head.push_back(b[k]);
      else tail.push_back(b[k]);
    clear_mon();
    start_load(11'h405);
    stream(head, 1'b0);
    checks++;
    if (Busy !== 1'b1) begin
      failures++;
      $display("FAIL clamp_busy got=%b want=1", Busy);
    end
    start_load(3);
    stream(with_chk(tail, model_xor(exp)), 1'b0);
    wait_done("clamp");
    bad = write_mismatches(exp);
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL clamp_writes mismatches=%0d got %0d writes want 1024", bad, wd_q.size());
    end
    checks++;
    if (wa_q.size() == 0 || wa_q[wa_q.size()-1] !== 10'h3FF || WrAddr !== 10'h000) begin
      failures++;
      $display("FAIL clamp_addr last=%h after=%h want 3ff/000",
               wa_q.size() ? wa_q[wa_q.size()-1] : 10'h0, WrAddr);
    end
    check_stream_rules("clamp");
  endtask

`ifdef INST_LOADER_CHECKSUM_EN
  task automatic test_chk_err();
    clear_mon();
    start_load(3);
    stream('{8'h01, 8'h00, 8'hFF, 8'h01, 8'h2A, 8'h00, 8'h00, 8'h00}, 1'b1);
    wait_done("chkerr");
    checks++;
    if (ChkErr !== 1'b1) begin
      failures++;
      $display("FAIL chkerr_set got=%b want=1", ChkErr);
    end
    start_load(0);
    @(negedge Clk);
    checks++;
    if (ChkErr !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL chkerr_clear chk=%b done=%b want 0/0", ChkErr, Done);
    end
    @(posedge Clk); #1;
    stream('{8'h00, 8'h00}, 1'b0);
    wait_done("chkzero");
  endtask
`endif

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    LoadLen = '0;
    ByteIn = '0;
    ByteValid = 1'b0;
    test_reset();
    test_basic();
    test_random_valid();
    test_zero_len();
    test_reset_mid();
    test_busy_clamp();
`ifdef INST_LOADER_CHECKSUM_EN
    test_chk_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
